// File: rtl/gate_seq_pkg.sv
// Shared types for the gate truth-table sequencer: FSM state encoding.
package gate_seq_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/gate_seq_settle_timer.sv
// Loadable down-counter that times how long gate_in is held in DRIVE.
// expire pulses on the last held cycle so the FSM leaves DRIVE on that edge.
module gate_seq_settle_timer #(
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(LOAD_VAL + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = CW'(LOAD_VAL);
    else if (en && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Count value 1 means this is the final settle cycle.
  assign expire = en && !load && (cnt_q == CW'(1));
endmodule

// File: rtl/gate_truth_sequencer.sv
// Sweeps every input row of a gate under check, captures its output and compares to EXPECT.
// Optional GATE_SEQ_STOP_ON_FAIL_EN: end the sweep on the first mismatching row.
module gate_truth_sequencer
  import gate_seq_pkg::*;
#(
  parameter int                     N_IN          = 2,
  parameter int                     SETTLE_CYCLES = 1,
  parameter logic [(1<<N_IN)-1:0]   EXPECT        = 4'b1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  gate_out,
  output logic [N_IN-1:0]       gate_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_IN:0]         fail_count,
  output logic [(1<<N_IN)-1:0]  result_vec
);
  localparam int NV = 1 << N_IN;

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] gate_in_q, gate_in_d;
  logic [N_IN:0]   fail_q, fail_d;
  logic [NV-1:0]   res_q, res_d;
  logic            tmr_load, tmr_en, tmr_expire;
  logic            mismatch, last_row, finish;

  gate_seq_settle_timer #(
    .LOAD_VAL (SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  assign mismatch = (gate_out != EXPECT[idx_q]);
  assign last_row = (idx_q == '1);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
  assign finish = last_row || mismatch;
`else
  assign finish = last_row;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gate_in_d = gate_in_q;
    fail_d    = fail_q;
    res_d     = res_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_DRIVE;
          idx_d     = '0;
          gate_in_d = '0;
          fail_d    = '0;
          res_d     = '0;
          tmr_load  = 1'b1;
        end
      end
      ST_DRIVE: begin
        tmr_en = 1'b1;
        if (tmr_expire) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        res_d[idx_q] = gate_out;
        if (mismatch) fail_d = fail_q + 1'b1;
        if (finish) begin
          state_d   = ST_DONE;
          gate_in_d = '0;
        end else begin
          state_d   = ST_DRIVE;
          idx_d     = idx_q + 1'b1;
          gate_in_d = idx_q + 1'b1;
          tmr_load  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      gate_in_q <= '0;
      fail_q    <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gate_in_q <= gate_in_d;
      fail_q    <= fail_d;
      res_q     <= res_d;
    end
  end

  assign gate_in    = gate_in_q;
  assign busy       = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (fail_q == '0);
  assign fail_count = fail_q;
  assign result_vec = res_q;
endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench for gate_truth_sequencer: AND-expect instance plus an OR-expect instance.
module tb_gate_truth_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;  // 0 AND, 1 stuck-0, 2 OR, 3 stuck-1

  logic       gate_out, busy, done, pass;
  logic [1:0] gate_in;
  logic [2:0] fail_count;
  logic [3:0] result_vec;

  logic       gate_out_o, busy_o, done_o, pass_o;
  logic [1:0] gate_in_o;
  logic [2:0] fail_count_o;
  logic [3:0] result_vec_o;

  int n_chk = 0;
  int n_pass = 0;
  int lat;

  always #5 clk = ~clk;

  function automatic logic model(input logic [1:0] m, input logic [1:0] gi);
    case (m)
      2'd0:    return gi[1] & gi[0];
      2'd1:    return 1'b0;
      2'd2:    return gi[1] | gi[0];
      default: return 1'b1;
    endcase
  endfunction

  assign gate_out   = model(mode, gate_in);
  assign gate_out_o = model(mode, gate_in_o);

  gate_truth_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_out(gate_out),
    .gate_in(gate_in), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .result_vec(result_vec)
  );

  gate_truth_sequencer #(.EXPECT(4'b1110)) dut_or (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_out(gate_out_o),
    .gate_in(gate_in_o), .busy(busy_o), .done(done_o), .pass(pass_o),
    .fail_count(fail_count_o), .result_vec(result_vec_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  // Assert start across one rising edge (E0); returns #1 after E0.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after E0 until done; optionally re-asserts start before edge `poke`.
  task automatic wait_done(input int poke, output int l);
    l = 0;
    while (!done && l < 64) begin
      if (l + 1 == poke) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      l++;
    end
  endtask

  initial begin
    #12;
    chk("rst_gate_in", gate_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_result", result_vec, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: ideal AND, check each held row
    mode = 2'd0;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1_gate_in_%0d", k), gate_in, k >> 1);
      chk($sformatf("t1_busy_%0d", k), busy, 1);
      chk($sformatf("t1_done_low_%0d", k), done, 0);
      @(posedge clk); #1;
    end
    chk("t1_done", done, 1);
    chk("t1_result", result_vec, 4'b1000);
    chk("t1_fail", fail_count, 0);
    chk("t1_pass", pass, 1);
    chk("t1_gate_in_idle", gate_in, 0);
    chk("t1_busy_idle", busy, 0);

    // 2: stuck-at-0
    mode = 2'd1;
    pulse_start();
    chk("t2_done_drop", done, 0);
    wait_done(0, lat);
    chk("t2_latency", lat, 8);
    chk("t2_result", result_vec, 4'b0000);
    chk("t2_fail", fail_count, 1);
    chk("t2_pass", pass, 0);

    // 3: OR gate against AND and OR expectations
    mode = 2'd2;
    pulse_start();
    wait_done(0, lat);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    chk("t3_latency", lat, 4);
    chk("t3_result", result_vec, 4'b0010);
    chk("t3_fail", fail_count, 1);
`else
    chk("t3_latency", lat, 8);
    chk("t3_result", result_vec, 4'b1110);
    chk("t3_fail", fail_count, 2);
`endif
    chk("t3_pass", pass, 0);
    for (int k = 0; k < 16 && !done_o; k++) begin
      @(posedge clk); #1;
    end
    chk("t3_or_done", done_o, 1);
    chk("t3_or_result", result_vec_o, 4'b1110);
    chk("t3_or_fail", fail_count_o, 0);
    chk("t3_or_pass", pass_o, 1);

    // 4: start during sweep is ignored; start in DONE restarts
    mode = 2'd0;
    pulse_start();
    wait_done(3, lat);
    chk("t4_latency_poked", lat, 8);
    chk("t4_fail", fail_count, 0);
    chk("t4_pass", pass, 1);
    pulse_start();
    chk("t4_restart_done", done, 0);
    chk("t4_restart_pass", pass, 0);
    chk("t4_restart_busy", busy, 1);
    wait_done(0, lat);
    chk("t4_latency_restart", lat, 8);
    chk("t4_result", result_vec, 4'b1000);

    // 5: asynchronous reset mid-sweep
    mode = 2'd3;
    pulse_start();
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("t5_gate_in", gate_in, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_pass", pass, 0);
    chk("t5_fail", fail_count, 0);
    chk("t5_result", result_vec, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mode = 2'd0;
    @(posedge clk); #1;
    pulse_start();
    wait_done(0, lat);
    chk("t5_latency", lat, 8);
    chk("t5_sweep_result", result_vec, 4'b1000);
    chk("t5_sweep_pass", pass, 1);

    // 6: stuck-at-1
    mode = 2'd3;
    pulse_start();
    wait_done(0, lat);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    chk("t6_latency", lat, 2);
    chk("t6_result", result_vec, 4'b0001);
    chk("t6_fail", fail_count, 1);
`else
    chk("t6_latency", lat, 8);
    chk("t6_result", result_vec, 4'b1111);
    chk("t6_fail", fail_count, 3);
`endif
    chk("t6_pass", pass, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
